// File: rtl/sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_pkg;

   // Controller phases: idle, low half-word, high half-word, completion
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_e;

   // Half-word select, appended as SRAM address bit 0
   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   // Legal range for cycles per half-word phase
   localparam int unsigned WAIT_CYCLES_MIN = 2;
   localparam int unsigned WAIT_CYCLES_MAX = 15;

   // Phase counter width, wide enough for WAIT_CYCLES_MAX-1
   localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data memory responder: serves 32-bit requests from a 16-bit
// asynchronous SRAM in two half-word phases, freezing the pipeline meanwhile.
// Optional feature: SRAM_POSTED_WRITE_EN (writes complete in the background).
module sram_controller
   import sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned ADDR_W      = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              ready,
   output logic              freeze,
   inout  wire  [15:0]       SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_WE_N
);

   if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
      $error("sram_controller: WAIT_CYCLES out of range");
   end

   sram_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-2:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [15:0]       rd_lo_q, rd_lo_d;
   logic [31:0]       read_data_q, read_data_d;
   logic              cnt_last;
   logic              phase_active;
   logic              posted_accept;
   logic [15:0]       dq_out;
   logic              unused_addr;
`ifdef SRAM_POSTED_WRITE_EN
   logic              posted_q, posted_d;
`endif

   assign unused_addr  = ^{address[31:ADDR_W+1], address[1:0]};
   assign cnt_last     = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
   assign phase_active = (state_q == LOW) || (state_q == HIGH);
   assign read_data    = read_data_q;

   // Register update with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_lo_q     <= '0;
         read_data_q <= '0;
`ifdef SRAM_POSTED_WRITE_EN
         posted_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_lo_q     <= rd_lo_d;
         read_data_q <= read_data_d;
`ifdef SRAM_POSTED_WRITE_EN
         posted_q    <= posted_d;
`endif
      end
   end

   // Next-state: request latch, phase counting and read half-word capture
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_wr_d       = op_wr_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rd_lo_d       = rd_lo_q;
      read_data_d   = read_data_q;
      posted_accept = 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
      posted_d      = posted_q;
`endif
      case (state_q)
         IDLE: begin
            if (rd_en || wr_en) begin
               state_d = LOW;
               cnt_d   = '0;
               op_wr_d = wr_en;
               addr_d  = address[ADDR_W:2];
               wdata_d = write_data;
`ifdef SRAM_POSTED_WRITE_EN
               posted_d      = wr_en;
               posted_accept = wr_en;
`endif
            end
         end
         LOW: begin
            if (cnt_last) begin
               state_d = HIGH;
               cnt_d   = '0;
               if (!op_wr_q) rd_lo_d = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (cnt_last) begin
               state_d = DONE;
               cnt_d   = '0;
               if (!op_wr_q) read_data_d = {SRAM_DQ, rd_lo_q};
`ifdef SRAM_POSTED_WRITE_EN
               // A posted write already acknowledged; skip DONE so no second ready
               if (posted_q) begin
                  state_d  = IDLE;
                  posted_d = 1'b0;
               end
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: handshake, stall and SRAM strobes derived from current phase
   always_comb begin
      ready     = (state_q == DONE) || posted_accept;
      freeze    = (rd_en || wr_en) && (state_q != DONE) && !posted_accept;
      SRAM_ADDR = '0;
      dq_out    = wdata_q[15:0];
      if (state_q == LOW) begin
         SRAM_ADDR = {addr_q, HALF_LO};
      end else if (state_q == HIGH) begin
         SRAM_ADDR = {addr_q, HALF_HI};
         dq_out    = wdata_q[31:16];
      end
      SRAM_WE_N = !(phase_active && op_wr_q && !cnt_last);
   end

   assign SRAM_DQ = (phase_active && op_wr_q) ? dq_out : 16'bz;

endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory responder for the MEM stage of the five-stage pipeline. Accepts 32-bit read/write requests from the MEM stage and serves them from an external 16-bit asynchronous SRAM in two half-word phases. While a request is in progress it drives `freeze` to hold every pipeline register, including the MEM/WB register. It then returns the 32-bit load word that the MEM/WB register captures as `data_mem`.

## Interface
- `WAIT_CYCLES`, default 2: cycles per half-word phase; legal range 2..15.
- `ADDR_W`, default 18: SRAM address width (half-word granular).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous reset, active-low (asserted at 0); release is synchronous to `clk` externally.
- `rd_en` in 1: load request from the MEM stage.
- `wr_en` in 1: store request from the MEM stage.
- `address` in 32: byte address, already offset to the data-memory base; bits [1:0] ignored.
- `write_data` in 32: store data.
- `read_data` out 32: load word; holds its value until the next completed read.
- `ready` out 1: one-cycle pulse when a request completes.
- `freeze` out 1: stall for all pipeline registers.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out ADDR_W: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE, with `rd_en|wr_en`: latch op, `address` and `write_data` → LOW with phase counter at 0.
- Operation priority: `wr_en` wins when both enables are high; a write never updates `read_data`.
- LOW: `SRAM_ADDR = {address[ADDR_W:2], 1'b0}`. After WAIT_CYCLES cycles → HIGH.
- HIGH: `SRAM_ADDR = {address[ADDR_W:2], 1'b1}`. After WAIT_CYCLES cycles → DONE.
- Write phases:
  - `SRAM_DQ` carries the low half in LOW and the high half in HIGH.
  - `SRAM_WE_N = 0` in every phase cycle except the last.
- Read phases:
  - `SRAM_DQ` is high-Z.
  - The low half is captured on the last LOW cycle and the high half on the last HIGH cycle.
  - `read_data = {high, low}` is updated on entry to DONE.
- DONE: `ready = 1` → IDLE unconditionally. The request still present during DONE is the old one and is not restarted.
- `freeze = (rd_en|wr_en) & (state != DONE)`, combinational. Outside of active requests `freeze = 0`.
- Request inputs may change mid-operation; they are ignored until the next IDLE.
- Reset, including mid-operation, sets:
  - state IDLE, counter 0;
  - `read_data = 0`, `ready = 0`;
  - `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `SRAM_ADDR = 0`.
- An in-flight write may be partially performed; this is accepted.

## Timing
- Request seen in IDLE at cycle 0:
  - `freeze` is high for cycles 0..2·WAIT_CYCLES.
  - DONE occurs at cycle 2·WAIT_CYCLES+1, with `freeze = 0` and `ready = 1`.
  - The pipeline advances on the edge ending DONE.
- Default WAIT_CYCLES=2 gives 5 stall cycles.
- `SRAM_ADDR` and write data are stable for the whole phase, giving one cycle of hold after `SRAM_WE_N` rises.
- Back-to-back requests: the next request starts in the IDLE cycle after DONE. The minimum period is 2·WAIT_CYCLES+2 cycles.

## Configuration
- `SRAM_POSTED_WRITE_EN` defined:
  - A write arriving in IDLE with the buffer empty is latched with `freeze = 0` and `ready` pulsed in the same cycle. The SRAM write then proceeds in the background (LOW/HIGH, then straight to IDLE without `ready`).
  - Any request arriving while the background write is busy is frozen until the write finishes, then served normally.
- Macro undefined: all writes stall as described in Operation.

## Structure
- Package `sram_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE);
  - half-word select constants;
  - `WAIT_CYCLES` legal-range constants.
- No sub-module. The phase counter and FSM stay inline; the tristate driver is a single continuous assignment.

## Test plan
- Read, WAIT_CYCLES=2, `address=0x0000_0010`, SRAM model holds 0xBEEF at half-address 8 and 0xDEAD at 9:
  - `freeze` high 5 cycles;
  - `ready` pulses once;
  - `read_data=0xDEAD_BEEF`.
- Write `0x1234_5678` to `0x0000_0020`:
  - SRAM model half-address 16 holds 0x5678 and 17 holds 0x1234;
  - `SRAM_WE_N` is low exactly 1 cycle per phase;
  - `read_data` unchanged.
- `rd_en=wr_en=1`, `write_data=0xA5A5_A5A5`: a write occurs and `read_data` keeps its prior value.
- Reset asserted in HIGH of a read:
  - outputs are at reset values immediately (`read_data=0`, `SRAM_WE_N=1`, bus high-Z);
  - a fresh read after release completes normally.
- Back-to-back reads to 0x10 then 0x14: second `ready` arrives exactly 6 cycles after the first, with no restart of the first request in DONE.
- With `SRAM_POSTED_WRITE_EN`: a write followed by an immediate read of the same word:
  - the write shows `freeze=0` and a `ready` pulse;
  - the read is frozen 4 + 5 cycles and returns the written value.
